// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline register with valid/ready handshake, two-entry skid buffer,
// synchronous flush and a saturating count of instructions squashed by flush.
module if_id_skid_stage #(
  parameter int INSTR_W    = 8,
  parameter int PC_W       = 8,
  parameter int CLEAR_DATA = 1,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [CNT_W-1:0]   flush_drop_cnt
);

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  state_t             state;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;
  logic               acc;
  logic               take;
  logic [1:0]         drop;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [1:0]       d);
    logic [CNT_W+1:0] s;
    logic [CNT_W-1:0] max;
    max = '1;
    s   = (CNT_W+2)'(c) + (CNT_W+2)'(d);
    if (s > (CNT_W+2)'(max)) return max;
    else return s[CNT_W-1:0];
  endfunction

  // ready depends only on registered state and reset, never on out_ready
  assign in_ready  = rst & (state != SKID);
  assign out_valid = (state != EMPTY);
  assign acc       = in_valid & in_ready;
  assign take      = out_valid & out_ready;
  assign drop      = 2'(out_valid & ~take) + 2'(state == SKID) + 2'(acc);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= EMPTY;
      out_instr      <= '0;
      out_pc         <= '0;
      skid_instr     <= '0;
      skid_pc        <= '0;
      flush_drop_cnt <= '0;
    end else if (flush) begin
      state          <= EMPTY;
      flush_drop_cnt <= sat_add(flush_drop_cnt, drop);
      if (CLEAR_DATA != 0) begin
        out_instr  <= '0;
        out_pc     <= '0;
        skid_instr <= '0;
        skid_pc    <= '0;
      end
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            out_instr <= in_instr;
            out_pc    <= in_pc;
            state     <= FULL;
          end
        end
        FULL: begin
          if (acc && take) begin
            out_instr <= in_instr;
            out_pc    <= in_pc;
          end else if (acc) begin
            skid_instr <= in_instr;
            skid_pc    <= in_pc;
            state      <= SKID;
          end else if (take) begin
            state <= EMPTY;
          end
        end
        SKID: begin
          if (take) begin
            out_instr <= skid_instr;
            out_pc    <= skid_pc;
            state     <= FULL;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage: three instances share stimulus
// (defaults, CLEAR_DATA=0, CNT_W=2) so data-hold and saturation can be observed.
module tb_if_id_skid_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_instr = '0;
  logic [7:0] in_pc = '0;
  logic       out_ready = 1'b0;

  logic       in_ready0, out_valid0, in_ready1, out_valid1, in_ready2, out_valid2;
  logic [7:0] out_instr0, out_pc0, cnt0, out_instr1, out_pc1, cnt1, out_instr2, out_pc2;
  logic [1:0] cnt2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  if_id_skid_stage #(.INSTR_W(8), .PC_W(8), .CLEAR_DATA(1), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid0), .out_ready(out_ready),
    .out_instr(out_instr0), .out_pc(out_pc0), .flush_drop_cnt(cnt0));

  if_id_skid_stage #(.INSTR_W(8), .PC_W(8), .CLEAR_DATA(0), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid1), .out_ready(out_ready),
    .out_instr(out_instr1), .out_pc(out_pc1), .flush_drop_cnt(cnt1));

  if_id_skid_stage #(.INSTR_W(8), .PC_W(8), .CLEAR_DATA(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid2), .out_ready(out_ready),
    .out_instr(out_instr2), .out_pc(out_pc2), .flush_drop_cnt(cnt2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    total++; if (out_valid0 !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid0); else passed++;
    total++; if (in_ready0 !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready0); else passed++;
    total++; if (cnt0 !== 8'd0) $display("FAIL reset_cnt got %0d want 0", cnt0); else passed++;
    rst = 1'b1;
    #1;
    total++; if (in_ready0 !== 1'b1) $display("FAIL reset_release_ready got %b want 1", in_ready0); else passed++;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 8'hA1; in_pc = 8'h10;
    tick();
    in_instr = 8'hA2; in_pc = 8'h11;
    tick();
    in_valid = 1'b0;
    total++; if (in_ready0 !== 1'b0) $display("FAIL mid_skid_ready got %b want 0", in_ready0); else passed++;
    total++; if (out_instr0 !== 8'hA1) $display("FAIL mid_skid_instr got %h want a1", out_instr0); else passed++;
    rst = 1'b0;
    tick();
    total++; if (out_valid0 !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", out_valid0); else passed++;
    total++; if (out_instr0 !== 8'h00) $display("FAIL mid_rst_instr got %h want 00", out_instr0); else passed++;
    total++; if (out_pc0 !== 8'h00) $display("FAIL mid_rst_pc got %h want 00", out_pc0); else passed++;
    total++; if (in_ready0 !== 1'b0) $display("FAIL mid_rst_ready got %b want 0", in_ready0); else passed++;
    total++; if (cnt0 !== 8'd0) $display("FAIL mid_rst_cnt got %0d want 0", cnt0); else passed++;
    rst = 1'b1;
    tick();
    total++; if (in_ready0 !== 1'b1) $display("FAIL mid_after_rst_ready got %b want 1", in_ready0); else passed++;
    total++; if (out_valid0 !== 1'b0) $display("FAIL mid_after_rst_valid got %b want 0", out_valid0); else passed++;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_pc = 8'(i); in_instr = 8'(i + 8'h40);
      total++; if (in_ready0 !== 1'b1) $display("FAIL stream_ready[%0d] got %b want 1", i, in_ready0); else passed++;
      tick();
      total++; if (out_valid0 !== 1'b1) $display("FAIL stream_valid[%0d] got %b want 1", i, out_valid0); else passed++;
      total++; if (out_pc0 !== 8'(i)) $display("FAIL stream_pc[%0d] got %h want %h", i, out_pc0, 8'(i)); else passed++;
      total++; if (out_instr0 !== 8'(i + 8'h40)) $display("FAIL stream_instr[%0d] got %h want %h", i, out_instr0, 8'(i + 8'h40)); else passed++;
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid0 !== 1'b0) $display("FAIL stream_drain got %b want 0", out_valid0); else passed++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 8'h31; in_pc = 8'h31;
    tick();
    in_instr = 8'h32; in_pc = 8'h32;
    tick();
    in_instr = 8'h33; in_pc = 8'h33;
    total++; if (in_ready0 !== 1'b0) $display("FAIL bp_ready got %b want 0", in_ready0); else passed++;
    total++; if (out_instr0 !== 8'h31) $display("FAIL bp_out0 got %h want 31", out_instr0); else passed++;
    tick();
    total++; if (out_instr0 !== 8'h31) $display("FAIL bp_hold got %h want 31", out_instr0); else passed++;
    total++; if (out_valid0 !== 1'b1) $display("FAIL bp_hold_valid got %b want 1", out_valid0); else passed++;
    out_ready = 1'b1;
    tick();
    total++; if (out_instr0 !== 8'h32) $display("FAIL bp_out1 got %h want 32", out_instr0); else passed++;
    total++; if (in_ready0 !== 1'b1) $display("FAIL bp_ready_back got %b want 1", in_ready0); else passed++;
    tick();
    in_valid = 1'b0;
    total++; if (out_instr0 !== 8'h33) $display("FAIL bp_out2 got %h want 33", out_instr0); else passed++;
    total++; if (out_pc0 !== 8'h33) $display("FAIL bp_out2_pc got %h want 33", out_pc0); else passed++;
    tick();
    total++; if (out_valid0 !== 1'b0) $display("FAIL bp_drain got %b want 0", out_valid0); else passed++;
  endtask

  task automatic test_flush_skid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 8'h51; in_pc = 8'h51;
    tick();
    in_instr = 8'h52; in_pc = 8'h52;
    tick();
    in_instr = 8'h53; in_pc = 8'h53;
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid0 !== 1'b0) $display("FAIL fskid_valid got %b want 0", out_valid0); else passed++;
    total++; if (cnt0 !== 8'd2) $display("FAIL fskid_cnt got %0d want 2", cnt0); else passed++;
    total++; if (out_instr0 !== 8'h00) $display("FAIL fskid_clear got %h want 00", out_instr0); else passed++;
    total++; if (out_valid1 !== 1'b0) $display("FAIL fskid_valid_nc got %b want 0", out_valid1); else passed++;
    total++; if (out_instr1 !== 8'h51) $display("FAIL fskid_hold_nc got %h want 51", out_instr1); else passed++;
    total++; if (cnt2 !== 2'd2) $display("FAIL fskid_cnt_w2 got %0d want 2", cnt2); else passed++;
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 8'h61; in_pc = 8'h61;
    tick();
    out_ready = 1'b1; in_instr = 8'h62; in_pc = 8'h62; flush = 1'b1;
    total++; if (out_instr0 !== 8'h61) $display("FAIL ffull_take got %h want 61", out_instr0); else passed++;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid0 !== 1'b0) $display("FAIL ffull_valid got %b want 0", out_valid0); else passed++;
    total++; if (cnt0 !== 8'd3) $display("FAIL ffull_cnt got %0d want 3", cnt0); else passed++;
    tick();
    total++; if (out_valid0 !== 1'b0) $display("FAIL ffull_no_ghost got %b want 0", out_valid0); else passed++;
  endtask

  task automatic test_saturation();
    logic [1:0] exp2 [3];
    exp2[0] = 2'd2; exp2[1] = 2'd3; exp2[2] = 2'd3;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_instr = 8'(8'h70 + k); in_pc = 8'(k);
      tick();
      tick();
      in_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      total++; if (cnt2 !== exp2[k]) $display("FAIL sat_cnt_w2[%0d] got %0d want %0d", k, cnt2, exp2[k]); else passed++;
      total++; if (cnt0 !== 8'(2 * (k + 1))) $display("FAIL sat_cnt_w8[%0d] got %0d want %0d", k, cnt0, 2 * (k + 1)); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_reset_midstream();
    test_streaming();
    test_backpressure();
    test_flush_skid();
    test_flush_full();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
